mem_wbuf: RTL and testbench



---
 rtl/mem_wbuf_pkg.sv | 20 ++
 rtl/mem_wbuf_if.sv | 47 ++++
 rtl/mem_wbuf_fifo.sv | 89 ++++++++
 rtl/mem_wbuf.sv | 207 ++++++++++++++++++++
 tb/tb_mem_wbuf.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wbuf_pkg
// Description : Shared types for the posted-write buffer (memory-side FSM).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wbuf_pkg;

  localparam int unsigned STATE_W = 2;

  // Memory-side sequencer states
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,  // nothing presented to memory
    WR    = 2'd1,  // head FIFO entry presented as a write
    RD    = 2'd2,  // pending read presented to memory
    RWAIT = 2'd3   // read accepted, waiting for returned data
  } state_e;

endpackage : mem_wbuf_pkg
`default_nettype wire

// File: rtl/mem_wbuf_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wbuf_if
// Description : Cache-side and memory-side request/response bundle for the
//               posted-write buffer. The slave view belongs to the buffer,
//               the master view to its environment (cache + memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wbuf_if #(
  parameter int AddrBusWidth = 5,
  parameter int DataWidth    = 8
) ();

  // Cache side
  logic [AddrBusWidth-1:0] up_addr;
  logic [DataWidth-1:0]    up_w_data;
  logic                    up_re;
  logic                    up_we;
  logic                    up_ready;
  logic [DataWidth-1:0]    up_r_data;
  logic                    up_r_data_valid;

  // Memory side
  logic [AddrBusWidth-1:0] mem_addr;
  logic [DataWidth-1:0]    mem_w_data;
  logic                    mem_re;
  logic                    mem_we;
  logic                    mem_ready;
  logic [DataWidth-1:0]    mem_r_data;
  logic                    mem_r_data_valid;

  modport slave (
    input  up_addr, up_w_data, up_re, up_we,
    output up_ready, up_r_data, up_r_data_valid,
    output mem_addr, mem_w_data, mem_re, mem_we,
    input  mem_ready, mem_r_data, mem_r_data_valid
  );

  modport master (
    output up_addr, up_w_data, up_re, up_we,
    input  up_ready, up_r_data, up_r_data_valid,
    input  mem_addr, mem_w_data, mem_re, mem_we,
    output mem_ready, mem_r_data, mem_r_data_valid
  );

endinterface : mem_wbuf_if
`default_nettype wire

// File: rtl/mem_wbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_wbuf_fifo
// Description : Write-entry storage for the posted-write buffer. Pointers
//               carry one extra wrap bit so all Depth slots are usable.
//               Every slot is exposed with a valid flag so the parent can
//               search buffered writes; rd_idx marks the oldest slot.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wbuf_fifo #(
  parameter int AddrBusWidth = 5,
  parameter int DataWidth    = 8,
  parameter int Depth        = 4
) (
  input  wire logic                                 clk,
  input  wire logic                                 rst,
  input  wire logic                                 push,
  input  wire logic [AddrBusWidth-1:0]              push_addr,
  input  wire logic [DataWidth-1:0]                 push_data,
  input  wire logic                                 pop,
  output logic                                      full,
  output logic                                      empty,
  output logic [AddrBusWidth-1:0]                   head_addr,
  output logic [DataWidth-1:0]                      head_data,
  output logic [Depth-1:0]                          ent_valid,
  output logic [Depth-1:0][AddrBusWidth-1:0]        ent_addr,
  output logic [Depth-1:0][DataWidth-1:0]           ent_data,
  output logic [$clog2(Depth)-1:0]                  rd_idx
);

  localparam int PtrW = $clog2(Depth);

  logic [PtrW:0]                        wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]                        rd_ptr_q, rd_ptr_d;
  logic [Depth-1:0][AddrBusWidth-1:0]   addr_q, addr_d;
  logic [Depth-1:0][DataWidth-1:0]      data_q, data_d;
  logic [PtrW:0]                        count;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == (PtrW+1)'(Depth));
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign rd_idx    = rd_ptr_q[PtrW-1:0];
  assign head_addr = addr_q[rd_idx];
  assign head_data = data_q[rd_idx];
  assign ent_addr  = addr_q;
  assign ent_data  = data_q;

  // A slot is live when its distance from the oldest slot is below the fill level
  generate
    for (genvar i = 0; i < Depth; i++) begin : g_ent
      logic [PtrW-1:0] off;
      assign off          = PtrW'(i) - rd_idx;
      assign ent_valid[i] = ({1'b0, off} < count);
    end
  endgenerate

  // Next-state for pointers and storage; writes land in the slot at wr_ptr
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (push) begin
      addr_d[wr_ptr_q[PtrW-1:0]] = push_addr;
      data_d[wr_ptr_q[PtrW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Register pointers and storage; reset empties the buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule : mem_wbuf_fifo
`default_nettype wire

// File: rtl/mem_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : mem_wbuf
// Description : Posted-write buffer between the cache memory port and the
//               backing memory. Writes are queued and drained in the
//               background; reads pass through one at a time.
//               Define MEM_WBUF_FWD_EN for store-to-load forwarding: reads
//               search the buffer (youngest match wins) and misses bypass
//               queued writes. Without it a read waits for a full drain.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wbuf
  import mem_wbuf_pkg::*;
#(
  parameter int AddrBusWidth = 5,
  parameter int DataWidth    = 8,
  parameter int Depth        = 4
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mem_wbuf_if.slave  bus
);

  localparam int PtrW = $clog2(Depth);

  state_e                    state_q, state_d;
  logic                      mem_re_q, mem_re_d;
  logic                      mem_we_q, mem_we_d;
  logic [AddrBusWidth-1:0]   mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0]      mem_w_data_q, mem_w_data_d;
  logic [DataWidth-1:0]      up_r_data_q, up_r_data_d;
  logic                      up_r_data_valid_q, up_r_data_valid_d;
  logic                      rd_pending_q, rd_pending_d;
  logic [AddrBusWidth-1:0]   rd_addr_q, rd_addr_d;

  logic                              up_ready;
  logic                              push;
  logic                              pop;
  logic                              rd_acc;
  logic                              full;
  logic                              empty;
  logic [AddrBusWidth-1:0]           head_addr;
  logic [DataWidth-1:0]              head_data;
  logic [Depth-1:0]                  ent_valid;
  logic [Depth-1:0][AddrBusWidth-1:0] ent_addr;
  logic [Depth-1:0][DataWidth-1:0]   ent_data;
  logic [PtrW-1:0]                   rd_idx;
  logic                              fwd_hit;
  logic [DataWidth-1:0]              fwd_data;

  // Conservative ready: a pop on this edge does not open a slot until next cycle.
  // A simultaneous read+write request is taken as a write only.
  assign up_ready = !full && !rd_pending_q;
  assign push     = up_ready && bus.up_we;
  assign rd_acc   = up_ready && bus.up_re && !bus.up_we;

  mem_wbuf_fifo #(
    .AddrBusWidth (AddrBusWidth),
    .DataWidth    (DataWidth),
    .Depth        (Depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (bus.up_addr),
    .push_data (bus.up_w_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .rd_idx    (rd_idx)
  );

`ifdef MEM_WBUF_FWD_EN
  logic [PtrW-1:0] fwd_idx;

  // Walk live entries oldest to youngest so the last match (youngest) wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < Depth; k++) begin
      fwd_idx = rd_idx + PtrW'(k);
      if (ent_valid[fwd_idx] && (ent_addr[fwd_idx] == bus.up_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[fwd_idx];
      end
    end
  end
`else
  logic unused_fwd;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
  assign unused_fwd = ^{ent_valid, ent_addr, ent_data, rd_idx};
`endif

  // Next-state: read capture/forward on the cache side, request sequencing on the memory side
  always_comb begin
    state_d           = state_q;
    mem_re_d          = mem_re_q;
    mem_we_d          = mem_we_q;
    mem_addr_d        = mem_addr_q;
    mem_w_data_d      = mem_w_data_q;
    up_r_data_d       = up_r_data_q;
    up_r_data_valid_d = 1'b0;
    rd_pending_d      = rd_pending_q;
    rd_addr_d         = rd_addr_q;
    pop               = 1'b0;

    if (rd_acc) begin
      if (fwd_hit) begin
        up_r_data_d       = fwd_data;
        up_r_data_valid_d = 1'b1;
      end else begin
        rd_pending_d = 1'b1;
        rd_addr_d    = bus.up_addr;
      end
    end

    case (state_q)
      IDLE: begin
`ifdef MEM_WBUF_FWD_EN
        if (rd_pending_q) begin
`else
        if (rd_pending_q && empty) begin
`endif
          state_d    = RD;
          mem_re_d   = 1'b1;
          mem_addr_d = rd_addr_q;
        end else if (!empty) begin
          state_d      = WR;
          mem_we_d     = 1'b1;
          mem_addr_d   = head_addr;
          mem_w_data_d = head_data;
        end else if (push) begin
          // Empty buffer: present the incoming write straight away; it is
          // also the head entry from the next cycle on.
          state_d      = WR;
          mem_we_d     = 1'b1;
          mem_addr_d   = bus.up_addr;
          mem_w_data_d = bus.up_w_data;
        end
      end
      WR: begin
        if (bus.mem_ready) begin
          pop      = 1'b1;
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD: begin
        if (bus.mem_ready) begin
          mem_re_d = 1'b0;
          state_d  = RWAIT;
        end
      end
      RWAIT: begin
        if (bus.mem_r_data_valid) begin
          up_r_data_d       = bus.mem_r_data;
          up_r_data_valid_d = 1'b1;
          rd_pending_d      = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register FSM state and all outputs; reset drops queued work and any pending read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      mem_re_q          <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_w_data_q      <= '0;
      up_r_data_q       <= '0;
      up_r_data_valid_q <= 1'b0;
      rd_pending_q      <= 1'b0;
      rd_addr_q         <= '0;
    end else begin
      state_q           <= state_d;
      mem_re_q          <= mem_re_d;
      mem_we_q          <= mem_we_d;
      mem_addr_q        <= mem_addr_d;
      mem_w_data_q      <= mem_w_data_d;
      up_r_data_q       <= up_r_data_d;
      up_r_data_valid_q <= up_r_data_valid_d;
      rd_pending_q      <= rd_pending_d;
      rd_addr_q         <= rd_addr_d;
    end
  end

  assign bus.up_ready        = up_ready;
  assign bus.up_r_data       = up_r_data_q;
  assign bus.up_r_data_valid = up_r_data_valid_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_w_data      = mem_w_data_q;
  assign bus.mem_re          = mem_re_q;
  assign bus.mem_we          = mem_we_q;

endmodule : mem_wbuf
`default_nettype wire

// File: tb/tb_mem_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wbuf
// Description : Directed scoreboard bench for mem_wbuf (5-bit addr, 8-bit
//               data, depth 4). A reference memory predicts read data, a
//               write queue predicts memory write order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wbuf;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  int   errors = 0;
  int   checks = 0;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_wbuf_if #(.AddrBusWidth(5), .DataWidth(8)) bus ();

  mem_wbuf #(
    .AddrBusWidth (5),
    .DataWidth    (8),
    .Depth        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MEM_WBUF_FWD_EN
  localparam int EXP_WQ_AT_RE = 1;
`else
  localparam int EXP_WQ_AT_RE = 0;
`endif

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [4:0] mrq[$];
  logic [7:0] mem_arr [32];
  logic [7:0] ref_mem [32];
  int         rsp_cnt = 0;
  logic [4:0] rsp_addr = '0;
  logic       legit_rsp = 1'b0;
  logic       exp_urv = 1'b0;
  logic       snap_hit = 1'b0;
  logic       last_up_acc = 1'b0;
  int         wq_at_re = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor/scoreboard at negedge, memory responder after posedge
  task automatic cycle();
    wr_t w;
    @(negedge clk);
    snap_hit = 1'b0;
    foreach (wq[i]) if (wq[i].a == bus.up_addr) snap_hit = 1'b1;
    last_up_acc = bus.up_ready && (bus.up_re || bus.up_we);
    chk("up_r_data_valid", bus.up_r_data_valid, exp_urv);
    chk("stray_mem_we", bus.mem_we && (wq.size() == 0), 0);
    chk("stray_mem_re", bus.mem_re && (mrq.size() == 0), 0);
    if (bus.up_r_data_valid && rq.size() > 0)
      chk("up_r_data", bus.up_r_data, rq.pop_front());
    if (bus.mem_we && bus.mem_ready && wq.size() > 0) begin
      w = wq.pop_front();
      chk("mem_addr_wr", bus.mem_addr, w.a);
      chk("mem_w_data", bus.mem_w_data, w.d);
      mem_arr[bus.mem_addr] = bus.mem_w_data;
    end
    if (bus.mem_re && bus.mem_ready && mrq.size() > 0) begin
      chk("mem_addr_rd", bus.mem_addr, mrq.pop_front());
      wq_at_re = wq.size();
`ifndef MEM_WBUF_FWD_EN
      chk("read_after_drain", wq.size(), 0);
`endif
      rsp_cnt  = 2;
      rsp_addr = bus.mem_addr;
    end
    @(posedge clk);
    #1;
    exp_urv = legit_rsp;
    legit_rsp = 1'b0;
    bus.mem_r_data_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        bus.mem_r_data_valid = 1'b1;
        bus.mem_r_data       = mem_arr[rsp_addr];
        legit_rsp            = 1'b1;
      end
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    wr_t w;
    bus.up_addr = a;
    bus.up_w_data = d;
    bus.up_we = 1'b1;
    for (int n = 0; n < 64; n++) begin
      cycle();
      if (last_up_acc) begin
        bus.up_we = 1'b0;
        w.a = a;
        w.d = d;
        wq.push_back(w);
        ref_mem[a] = d;
        return;
      end
    end
    bus.up_we = 1'b0;
    chk("write_accept_timeout", last_up_acc, 1);
  endtask

  task automatic do_read(input logic [4:0] a);
    bus.up_addr = a;
    bus.up_re = 1'b1;
    for (int n = 0; n < 64; n++) begin
      cycle();
      if (last_up_acc) begin
        bus.up_re = 1'b0;
        rq.push_back(ref_mem[a]);
`ifdef MEM_WBUF_FWD_EN
        if (snap_hit) exp_urv = 1'b1;
        else mrq.push_back(a);
`else
        mrq.push_back(a);
`endif
        return;
      end
    end
    bus.up_re = 1'b0;
    chk("read_accept_timeout", last_up_acc, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (wq.size() == 0 && rq.size() == 0 && mrq.size() == 0 &&
          rsp_cnt == 0 && !legit_rsp && !exp_urv) break;
      cycle();
    end
    chk("drain_timeout", wq.size() + rq.size() + mrq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.up_addr = '0;
    bus.up_w_data = '0;
    bus.up_re = 1'b0;
    bus.up_we = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_r_data = '0;
    bus.mem_r_data_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = 8'(i) ^ 8'h4A;
      ref_mem[i] = 8'(i) ^ 8'h4A;
    end

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_up_ready", bus.up_ready, 1);
    chk("rst_up_r_data", bus.up_r_data, 0);
    chk("rst_up_r_data_valid", bus.up_r_data_valid, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_w_data", bus.mem_w_data, 0);
    rst = 1'b1;

    // Single write reaches memory one cycle after acceptance
    bus.mem_ready = 1'b1;
    do_write(5'h1B, 8'hC5);
    chk("t1_mem_we", bus.mem_we, 1);
    chk("t1_mem_addr", bus.mem_addr, 5'h1B);
    chk("t1_mem_w_data", bus.mem_w_data, 8'hC5);
    wait_idle(20);
    repeat (3) cycle();
    chk("t1_up_ready", bus.up_ready, 1);

    // Fill the buffer with memory stalled, then drain in order
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) do_write(5'(i), 8'hA0 + 8'(i));
    chk("t2_full_up_ready", bus.up_ready, 0);
    cycle();
    chk("t2_hold_mem_we", bus.mem_we, 1);
    chk("t2_hold_mem_addr", bus.mem_addr, 5'h01);
    bus.mem_ready = 1'b1;
    cycle();
    chk("t2_up_ready_after_pop", bus.up_ready, 1);
    wait_idle(40);

    // Memory read path, response two cycles after acceptance
    do_read(5'h10);
    chk("t3_up_ready_pending", bus.up_ready, 0);
    for (int n = 0; n < 30 && rq.size() > 0; n++) begin
      if (!bus.up_r_data_valid) chk("t3_up_ready_wait", bus.up_ready, 0);
      cycle();
    end
    wait_idle(20);
    chk("t3_up_ready_done", bus.up_ready, 1);

    // Unsolicited memory response is ignored
    bus.mem_r_data = 8'hEE;
    bus.mem_r_data_valid = 1'b1;
    cycle();
    cycle();
    chk("spur_up_r_data_hold", bus.up_r_data, 8'h5A);

    // Two writes to one address then a read of it
    bus.mem_ready = 1'b0;
    do_write(5'h1B, 8'h11);
    do_write(5'h1B, 8'h22);
    do_read(5'h1B);
`ifdef MEM_WBUF_FWD_EN
    cycle();
    chk("t4_fwd_no_mem_re", bus.mem_re, 0);
`else
    repeat (3) cycle();
    chk("t4_mem_re_held_off", bus.mem_re, 0);
`endif
    bus.mem_ready = 1'b1;
    wait_idle(60);

    // Read miss while writes are queued
    bus.mem_ready = 1'b0;
    do_write(5'h05, 8'h33);
    do_write(5'h06, 8'h44);
    wq_at_re = -1;
    do_read(5'h07);
    bus.mem_ready = 1'b1;
    wait_idle(60);
    chk("t5_writes_left_at_mem_re", wq_at_re, EXP_WQ_AT_RE);

    // Reset with queued writes and a pending read
    bus.mem_ready = 1'b0;
    do_write(5'h08, 8'hB8);
    do_write(5'h09, 8'hB9);
    do_write(5'h0A, 8'hBA);
    do_read(5'h0C);
    chk("t6_mem_we_before_rst", bus.mem_we, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_mem_we", bus.mem_we, 0);
    chk("t6_rst_mem_re", bus.mem_re, 0);
    chk("t6_rst_up_r_data_valid", bus.up_r_data_valid, 0);
    wq.delete();
    rq.delete();
    mrq.delete();
    rsp_cnt = 0;
    legit_rsp = 1'b0;
    exp_urv = 1'b0;
    bus.mem_r_data_valid = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = mem_arr[i];
    repeat (2) cycle();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (5) cycle();
    chk("t6_up_ready_after_rst", bus.up_ready, 1);
    do_read(5'h08);
    wait_idle(30);
    do_write(5'h0A, 8'h5C);
    do_read(5'h0A);
    wait_idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_wbuf
`default_nettype wire
